read_iq: RTL and testbench
==========================

// Module: read_iq
// PURPOSE
//  Front-end stage of fm_radio_top, directly downstream of the 8-bit input FIFO that the bench fills from usrp.dat.
//  Pops raw bytes and assembles each 4-byte group into one 16-bit I and one 16-bit Q sample (little-endian, signed).
//  Quantizes both samples to DATA_SIZE fixed point (<< BITS) and pushes them into the I and Q sample FIFOs
//  feeding the demodulator chain. All FIFO interfaces are first-word-fall-through.
// PARAMETERS
//  DATA_SIZE   32   width of quantized output samples
//  BYTE_SIZE   8    width of input FIFO data
//  BITS        10   fixed-point fraction bits (quantize = sample << BITS)
// PORTS
//  clock         in   1          system clock, all logic on rising edge
//  reset         in   1          asynchronous, active-low reset
//  in_empty      in   1          input FIFO empty
//  in_rd_en      out  1          input FIFO pop; in_dout valid when !in_empty
//  in_dout       in   BYTE_SIZE  input FIFO head byte
//  i_out_full    in   1          I sample FIFO full
//  i_out_wr_en   out  1          I sample FIFO push
//  i_out_din     out  DATA_SIZE  quantized I sample
//  q_out_full    in   1          Q sample FIFO full
//  q_out_wr_en   out  1          Q sample FIFO push
//  q_out_din     out  DATA_SIZE  quantized Q sample
// BEHAVIOUR
//  - Reset (reset==0, async): state=S_READ, byte_cnt=0, byte regs=0, all outputs 0; partial group discarded.
//  - FSM S_READ: in_rd_en = !in_empty (combinational). On a pop, in_dout is stored into byte slot byte_cnt,
//    and byte_cnt increments. A pop when byte_cnt==3 wraps byte_cnt to 0 and moves the FSM to S_WRITE.
//  - Byte order in a group: 0=I[7:0], 1=I[15:8], 2=Q[7:0], 3=Q[15:8].
//  - FSM S_WRITE: in_rd_en=0. If !i_out_full && !q_out_full, i_out_wr_en=q_out_wr_en=1 in the same cycle,
//    then the FSM moves to S_READ. Otherwise both wr_en stay 0 and the FSM holds in S_WRITE.
//  - I and Q are always pushed together; never one without the other.
//  - Arithmetic: sample = signed 16-bit {hi,lo}; sign-extend to DATA_SIZE, then shift left BITS.
//    Result is truncated to DATA_SIZE. i_out_din/q_out_din are combinational from the regs and are valid while wr_en=1.
//  - Throughput: minimum 5 cycles per I/Q pair (4 pops + 1 push). Empty cycles stall S_READ with no side effects.
//  - in_empty asserted mid-group: byte_cnt and stored bytes are held; assembly resumes on the next non-empty cycle.
//  - Full deasserting: the push occurs on the first cycle both fulls are 0. No data is lost or duplicated.
//  - Reset asserted mid-group or in S_WRITE: the pending sample is dropped and no push occurs.
// TESTING
//  1. bytes 34,12,78,56 -> one push: i_out_din=0x0048D000, q_out_din=0x0159E000, exactly one wr_en cycle.
//  2. bytes FF,FF,00,80 -> i_out_din=0xFFFFFC00 (-1<<10), q_out_din=0xFE000000 (-32768<<10).
//  3. Continuous 8-byte stream, fulls low -> 2 pushes, 10 cycles from the first pop to the second push inclusive,
//     in_rd_en low during each push cycle.
//  4. Group complete with i_out_full=1 for 6 cycles (q_out_full=0) -> no wr_en and in_rd_en=0 throughout;
//     a single joint push on the cycle after i_out_full drops.
//  5. in_empty toggled between every byte of group 1 -> values identical to test 1, no extra pops.
//  6. Reset pulsed low after 2 bytes, then bytes 34,12,78,56 -> only the test-1 pair appears; outputs 0 during reset.
//  Bench: first 32000 bytes of usrp.dat; the pushed I/Q pairs must match the golden I/Q text dumps exactly.

Source files
------------

// File: rtl/read_iq.sv
// Input-side stage of the FM receiver: collects four FIFO bytes into one signed
// 16-bit I/Q pair, scales both samples to fixed point and pushes them out together.
module read_iq #(
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int BITS      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic [BYTE_SIZE-1:0] in_dout,
    input  logic                 i_out_full,
    output logic                 i_out_wr_en,
    output logic [DATA_SIZE-1:0] i_out_din,
    input  logic                 q_out_full,
    output logic                 q_out_wr_en,
    output logic [DATA_SIZE-1:0] q_out_din
);

    localparam int SAMPLE_W = 2 * BYTE_SIZE;

    typedef enum logic {
        S_READ,
        S_WRITE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [1:0]                  byte_cnt;
    logic [3:0][BYTE_SIZE-1:0]   byte_reg;
    logic                        pop;
    logic                        push;
    logic signed [SAMPLE_W-1:0]  i_sample;
    logic signed [SAMPLE_W-1:0]  q_sample;
    logic signed [DATA_SIZE-1:0] i_ext;
    logic signed [DATA_SIZE-1:0] q_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_READ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_READ:  if (pop && byte_cnt == 2'd3) state_next = S_WRITE;
            S_WRITE: if (push) state_next = S_READ;
            default: state_next = S_READ;
        endcase
    end

    // Pop is also gated by reset so every output reads 0 while reset is held.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        case (state)
            S_READ:  pop  = reset && !in_empty;
            S_WRITE: push = !i_out_full && !q_out_full;
            default: begin
                pop  = 1'b0;
                push = 1'b0;
            end
        endcase
    end

    assign in_rd_en    = pop;
    assign i_out_wr_en = push;
    assign q_out_wr_en = push;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            byte_reg <= '0;
        end else if (pop) begin
            byte_reg[byte_cnt] <= in_dout;
            byte_cnt           <= byte_cnt + 2'd1;
        end
    end

    assign i_sample  = {byte_reg[1], byte_reg[0]};
    assign q_sample  = {byte_reg[3], byte_reg[2]};
    assign i_ext     = DATA_SIZE'(i_sample);
    assign q_ext     = DATA_SIZE'(q_sample);
    assign i_out_din = i_ext << BITS;
    assign q_out_din = q_ext << BITS;

endmodule

// File: tb/tb_read_iq.sv
// Scoreboard bench for read_iq: directed byte groups with hand-computed I/Q
// results queued at issue time, checked by an independent output monitor.
module tb_read_iq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [7:0]  in_dout = 8'h00;
    logic        i_out_full = 1'b0;
    logic        i_out_wr_en;
    logic [31:0] i_out_din;
    logic        q_out_full = 1'b0;
    logic        q_out_wr_en;
    logic [31:0] q_out_din;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int pushes = 0;
    int last_pop_cyc = 0;
    int last_push_cyc = 0;
    logic [63:0] exp_q[$];

    read_iq #(.DATA_SIZE(32), .BYTE_SIZE(8), .BITS(10)) dut (
        .clock(clock),
        .reset(reset),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .in_dout(in_dout),
        .i_out_full(i_out_full),
        .i_out_wr_en(i_out_wr_en),
        .i_out_din(i_out_din),
        .q_out_full(q_out_full),
        .q_out_wr_en(q_out_wr_en),
        .q_out_din(q_out_din)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Output monitor: every push is compared against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (in_rd_en && !in_empty) begin
                pops++;
                last_pop_cyc = cyc;
            end
            if (i_out_wr_en || q_out_wr_en) begin
                pushes++;
                last_push_cyc = cyc;
                check("wr_en_pair", {63'd0, q_out_wr_en}, {63'd0, i_out_wr_en});
                check("rd_during_push", {63'd0, in_rd_en}, 64'd0);
                check("push_while_full", {62'd0, i_out_full, q_out_full}, 64'd0);
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_push actual=%h/%h required=none", i_out_din, q_out_din);
                end else begin
                    check("iq_pair", {i_out_din, q_out_din}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit popped = 0;
        int n = 0;
        in_dout  = b;
        in_empty = 1'b0;
        while (!popped && n < 40) begin
            @(negedge clock);
            popped = in_rd_en;
            n++;
            @(posedge clock);
            #1;
        end
        in_empty = 1'b1;
        if (!popped) begin
            errors++;
            checks++;
            $display("FAIL pop_timeout actual=no_pop required=pop byte=%h", b);
        end
    endtask

    task automatic send_group(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clock);
        #1;
        check(name, {in_rd_en, i_out_wr_en, q_out_wr_en, i_out_din, q_out_din}, 64'd0);
    endtask

    initial begin
        int p0;
        int c0;
        int first_pop;

        // Reset state, with the input FIFO non-empty so an ungated pop would show.
        in_empty = 1'b0;
        in_dout  = 8'h5A;
        check_reset_outputs("reset_outputs_a");
        check_reset_outputs("reset_outputs_b");
        in_empty = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Test 1: basic group.
        p0 = pushes;
        c0 = pops;
        exp_q.push_back({32'h0048D000, 32'h0159E000});
        send_group(8'h34, 8'h12, 8'h78, 8'h56);
        wait_drain();
        check("t1_push_count", 64'(pushes - p0), 64'd1);
        check("t1_pop_count", 64'(pops - c0), 64'd4);

        // Test 2: negative extremes.
        exp_q.push_back({32'hFFFFFC00, 32'hFE000000});
        send_group(8'hFF, 8'hFF, 8'h00, 8'h80);
        wait_drain();

        // Test 3: back-to-back groups, 10 cycles first pop to second push inclusive.
        p0 = pushes;
        exp_q.push_back({32'h00000400, 32'h00000800});
        exp_q.push_back({32'h00000C00, 32'h00001000});
        send_byte(8'h01);
        first_pop = last_pop_cyc;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_group(8'h03, 8'h00, 8'h04, 8'h00);
        wait_drain();
        check("t3_push_count", 64'(pushes - p0), 64'd2);
        check("t3_latency", 64'(last_push_cyc - first_pop + 1), 64'd10);

        // Test 4: I FIFO full holds the pair; data waiting at the input must not be popped.
        i_out_full = 1'b1;
        exp_q.push_back({32'hFFB73000, 32'h00000000});
        send_group(8'hCC, 8'hED, 8'h00, 8'h00);
        p0 = pushes;
        c0 = pops;
        in_dout  = 8'hAA;
        in_empty = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            check("t4_rd_while_full", {63'd0, in_rd_en}, 64'd0);
        end
        check("t4_no_push_while_full", 64'(pushes - p0), 64'd0);
        @(posedge clock);
        #1;
        i_out_full = 1'b0;
        @(negedge clock);
        #1;
        check("t4_push_after_drop", 64'(pushes - p0), 64'd1);
        @(posedge clock);
        #1;
        in_empty = 1'b1;
        check("t4_no_extra_pop", 64'(pops - c0), 64'd0);
        wait_drain();

        // Q FIFO full alone must also hold the pair.
        q_out_full = 1'b1;
        exp_q.push_back({32'h01FFFC00, 32'hFFFFF800});
        send_group(8'hFF, 8'h7F, 8'hFE, 8'hFF);
        p0 = pushes;
        repeat (3) @(negedge clock);
        #1;
        check("q_full_hold", 64'(pushes - p0), 64'd0);
        @(posedge clock);
        #1;
        q_out_full = 1'b0;
        wait_drain();
        check("q_full_release", 64'(pushes - p0), 64'd1);

        // Test 5: empty cycle between every byte.
        c0 = pops;
        exp_q.push_back({32'h0048D000, 32'h0159E000});
        send_byte(8'h34); @(posedge clock); #1;
        send_byte(8'h12); @(posedge clock); #1;
        send_byte(8'h78); @(posedge clock); #1;
        send_byte(8'h56);
        wait_drain();
        check("t5_pop_count", 64'(pops - c0), 64'd4);

        // Test 6: reset mid-group drops the partial bytes.
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset    = 1'b0;
        in_dout  = 8'h55;
        in_empty = 1'b0;
        check_reset_outputs("t6_reset_outputs_a");
        check_reset_outputs("t6_reset_outputs_b");
        in_empty = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        p0 = pushes;
        exp_q.push_back({32'h0048D000, 32'h0159E000});
        send_group(8'h34, 8'h12, 8'h78, 8'h56);
        wait_drain();
        check("t6_push_count", 64'(pushes - p0), 64'd1);

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
